core_data_responder: RTL and testbench

- Subordinate-side terminator of the cluster core data protocol (req/add/we/data/be → gnt, r_valid, r_data).
- Sits between a core or peripheral-interconnect master port and a single-port SRAM-style memory with fixed read latency.
- Grants requests subject to memory arbitration and returns one in-order response per granted request, writes included.
- Out-of-range accesses get an error response and are counted.

---
 rtl/core_data_responder.sv | 135 +++++++++++++
 tb/tb_core_data_responder.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_data_responder.sv
// core_data_responder
//   Subordinate-side terminator of the cluster core data protocol. It sits
//   between a core/interconnect master port and a single-port SRAM with a
//   fixed read latency. Every granted request returns exactly one in-order
//   response, and that includes writes. A request outside the memory window
//   is granted at once and never reaches the memory. Its response carries
//   ERR_DATA and is counted in a saturating error counter.
//
// Ports
//   clk_i, rst_i          clock, asynchronous active-high reset
//   req_i/add_i/we_i/data_i/be_i   core request side
//   gnt_o                 request accepted this cycle
//   r_valid_o/r_data_o/r_err_o     response side (no back-pressure)
//   mem_req_o/mem_gnt_i   memory request / bank-arbitration grant
//   mem_addr_o/mem_we_o/mem_be_o/mem_wdata_o  memory command
//   mem_rdata_i           memory read data, RD_LATENCY cycles after grant
//   err_clr_i             synchronous clear of err_cnt_o
//   err_cnt_o             saturating count of error responses
module core_data_responder #(
  parameter int unsigned MEM_ADDR_WIDTH = 10,
  parameter logic [31:0] BASE_ADDR      = 32'h1000_0000,
  parameter int unsigned RD_LATENCY     = 1,
  parameter logic [31:0] ERR_DATA       = 32'hBADA_CCE5,
  parameter int unsigned ERR_CNT_WIDTH  = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      req_i,
  input  logic [31:0]               add_i,
  input  logic                      we_i,
  input  logic [31:0]               data_i,
  input  logic [3:0]                be_i,
  output logic                      gnt_o,
  output logic                      r_valid_o,
  output logic [31:0]               r_data_o,
  output logic                      r_err_o,
  output logic                      mem_req_o,
  input  logic                      mem_gnt_i,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr_o,
  output logic                      mem_we_o,
  output logic [3:0]                mem_be_o,
  output logic [31:0]               mem_wdata_o,
  input  logic [31:0]               mem_rdata_i,
  input  logic                      err_clr_i,
  output logic [ERR_CNT_WIDTH-1:0]  err_cnt_o
);

  if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_bad_latency
    $error("core_data_responder: RD_LATENCY must be in 1..4");
  end

  logic in_range;
  logic unused_addr_bits;

  // The window is aligned to its own size, so a compare of the upper bits is enough.
  assign in_range = (add_i[31:MEM_ADDR_WIDTH+2] == BASE_ADDR[31:MEM_ADDR_WIDTH+2]);
  // Byte-lane bits play no part in a word access.
  assign unused_addr_bits = ^add_i[1:0];

  assign mem_req_o   = req_i & in_range;
  assign gnt_o       = req_i & (~in_range | mem_gnt_i);
  assign mem_addr_o  = add_i[MEM_ADDR_WIDTH+1:2];
  assign mem_we_o    = we_i;
  assign mem_be_o    = be_i;
  assign mem_wdata_o = data_i;

  // The response pipeline is aligned with the memory read latency.
  // It never stalls because the protocol has no response ready.
  logic [RD_LATENCY-1:0] vld_q, vld_d;
  logic [RD_LATENCY-1:0] err_q, err_d;
  logic [RD_LATENCY-1:0] we_q,  we_d;

  always_comb begin
    vld_d    = '0;
    err_d    = '0;
    we_d     = '0;
    vld_d[0] = gnt_o;
    err_d[0] = ~in_range;
    we_d[0]  = we_i;
    for (int i = 1; i < RD_LATENCY; i++) begin
      vld_d[i] = vld_q[i-1];
      err_d[i] = err_q[i-1];
      we_d[i]  = we_q[i-1];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_q <= '0;
      err_q <= '0;
      we_q  <= '0;
    end else begin
      vld_q <= vld_d;
      err_q <= err_d;
      we_q  <= we_d;
    end
  end

  assign r_valid_o = vld_q[RD_LATENCY-1];
  assign r_err_o   = r_valid_o & err_q[RD_LATENCY-1];

  always_comb begin
    r_data_o = 32'h0;
    if (r_valid_o) begin
      if (err_q[RD_LATENCY-1]) begin
        r_data_o = ERR_DATA;
      end else if (!we_q[RD_LATENCY-1]) begin
        r_data_o = mem_rdata_i;
      end
    end
  end

  logic [ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;

  // A clear wins over a same-cycle error, and that error is lost.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_clr_i) begin
      err_cnt_d = '0;
    end else if (r_err_o && !(&err_cnt_q)) begin
      err_cnt_d = err_cnt_q + ERR_CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt_o = err_cnt_q;

endmodule

// File: tb/tb_core_data_responder.sv
// Testbench for core_data_responder. Two instances (RD_LATENCY 1 / 16-bit
// counter and RD_LATENCY 3 / 2-bit counter) share one stimulus stream and
// one SRAM model. Expected responses are queued when a request is issued
// and popped by a negedge monitor.
module tb_core_data_responder;
  localparam logic [31:0] BASE  = 32'h1000_0000;
  localparam int          AW    = 10;
  localparam int          LAT_A = 1;
  localparam int          LAT_B = 3;
  localparam logic [31:0] ERRD  = 32'hBADA_CCE5;
  localparam int          MAX_A = 65535;
  localparam int          MAX_B = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic [31:0] add = 32'h0;
  logic        we = 1'b0;
  logic [31:0] data = 32'h0;
  logic [3:0]  be = 4'h0;
  logic        mem_gnt = 1'b0;
  logic        err_clr = 1'b0;

  logic          gnt_a, r_valid_a, r_err_a, mem_req_a, mem_we_a;
  logic [31:0]   r_data_a, mem_wdata_a, mem_rdata_a;
  logic [AW-1:0] mem_addr_a;
  logic [3:0]    mem_be_a;
  logic [15:0]   err_cnt_a;

  logic          gnt_b, r_valid_b, r_err_b, mem_req_b, mem_we_b;
  logic [31:0]   r_data_b, mem_wdata_b, mem_rdata_b;
  logic [AW-1:0] mem_addr_b;
  logic [3:0]    mem_be_b;
  logic [1:0]    err_cnt_b;

  always #5 clk = ~clk;

  core_data_responder #(.MEM_ADDR_WIDTH(AW), .BASE_ADDR(BASE), .RD_LATENCY(LAT_A),
                        .ERR_DATA(ERRD), .ERR_CNT_WIDTH(16)) dut_a (
    .clk_i(clk), .rst_i(rst), .req_i(req), .add_i(add), .we_i(we), .data_i(data),
    .be_i(be), .gnt_o(gnt_a), .r_valid_o(r_valid_a), .r_data_o(r_data_a),
    .r_err_o(r_err_a), .mem_req_o(mem_req_a), .mem_gnt_i(mem_gnt),
    .mem_addr_o(mem_addr_a), .mem_we_o(mem_we_a), .mem_be_o(mem_be_a),
    .mem_wdata_o(mem_wdata_a), .mem_rdata_i(mem_rdata_a), .err_clr_i(err_clr),
    .err_cnt_o(err_cnt_a));

  core_data_responder #(.MEM_ADDR_WIDTH(AW), .BASE_ADDR(BASE), .RD_LATENCY(LAT_B),
                        .ERR_DATA(ERRD), .ERR_CNT_WIDTH(2)) dut_b (
    .clk_i(clk), .rst_i(rst), .req_i(req), .add_i(add), .we_i(we), .data_i(data),
    .be_i(be), .gnt_o(gnt_b), .r_valid_o(r_valid_b), .r_data_o(r_data_b),
    .r_err_o(r_err_b), .mem_req_o(mem_req_b), .mem_gnt_i(mem_gnt),
    .mem_addr_o(mem_addr_b), .mem_we_o(mem_we_b), .mem_be_o(mem_be_b),
    .mem_wdata_o(mem_wdata_b), .mem_rdata_i(mem_rdata_b), .err_clr_i(err_clr),
    .err_cnt_o(err_cnt_b));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] seed(int i);
    if (i == 4) return 32'hCAFE_F00D;
    return 32'(i) * 32'h9E37_79B1 + 32'h0123_4567;
  endfunction

  // SRAM model: a write lands at the grant edge, read data comes out after the fixed latency.
  // Cycles with no read drive junk so a response taken at the wrong time shows up.
  logic [31:0] sram [1024];
  logic [31:0] rd_a;
  logic [31:0] rd_b [3];
  bit          init_go = 1'b1;

  always @(posedge clk) begin
    if (init_go) begin
      for (int i = 0; i < 1024; i++) sram[i] <= seed(i);
    end else if (mem_req_a && mem_gnt && mem_we_a) begin
      for (int k = 0; k < 4; k++)
        if (mem_be_a[k]) sram[mem_addr_a][8*k +: 8] <= mem_wdata_a[8*k +: 8];
    end
    rd_a    <= (mem_req_a && mem_gnt && !mem_we_a) ? sram[mem_addr_a] : $urandom;
    rd_b[0] <= (mem_req_b && mem_gnt && !mem_we_b) ? sram[mem_addr_b] : $urandom;
    rd_b[1] <= rd_b[0];
    rd_b[2] <= rd_b[1];
  end
  assign mem_rdata_a = rd_a;
  assign mem_rdata_b = rd_b[2];

  // Reference model: a flat memory image, FIFOs of expected responses, error counts.
  typedef struct {
    int          due;
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic [31:0] ref_mem [1024];
  exp_t        q_a[$];
  exp_t        q_b[$];
  int          cnt_a = 0;
  int          cnt_b = 0;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic drive(input logic r, input logic [31:0] a, input logic w,
                       input logic [31:0] d, input logic [3:0] b,
                       input logic g, input logic c);
    bit   inr, gexp;
    int   word;
    exp_t e;
    @(posedge clk);
    #1;
    req = r; add = a; we = w; data = d; be = b; mem_gnt = g; err_clr = c;
    inr  = (a >= BASE) && (a < BASE + 32'(4 << AW));
    word = int'((a >> 2) % 1024);
    gexp = r && (!inr || g);
    if (gexp) begin
      e.err  = !inr;
      e.data = !inr ? ERRD : (w ? 32'h0 : ref_mem[word]);
      e.due  = cyc + LAT_A;
      q_a.push_back(e);
      e.due  = cyc + LAT_B;
      q_b.push_back(e);
      if (inr && w)
        for (int k = 0; k < 4; k++)
          if (b[k]) ref_mem[word][8*k +: 8] = d[8*k +: 8];
    end
    #1;
    chk("gnt_a", 64'(gnt_a), 64'(gexp));
    chk("gnt_b", 64'(gnt_b), 64'(gexp));
    chk("mem_req", 64'(mem_req_a), 64'(r && inr));
    chk("mem_addr", 64'(mem_addr_a), 64'(word));
    chk("mem_passthru", {27'h0, mem_we_a, mem_be_a, mem_wdata_a}, {27'h0, w, b, d});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1; req = 1'b0; mem_gnt = 1'b0; err_clr = 1'b0;
    q_a.delete();
    q_b.delete();
    cnt_a = 0;
    cnt_b = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Monitor: a response is expected exactly when the head of the queue falls due this cycle.
  always @(negedge clk) begin
    bit   due_a, due_b;
    exp_t h_a, h_b;
    chk("err_cnt_a", 64'(err_cnt_a), 64'(cnt_a));
    chk("err_cnt_b", 64'(err_cnt_b), 64'(cnt_b));
    due_a = (q_a.size() > 0) && (q_a[0].due == cyc);
    due_b = (q_b.size() > 0) && (q_b[0].due == cyc);
    if (due_a) begin
      h_a = q_a.pop_front();
      chk("a_rvalid", 64'(r_valid_a), 64'd1);
      chk("a_rdata", 64'(r_data_a), 64'(h_a.data));
      chk("a_rerr", 64'(r_err_a), 64'(h_a.err));
    end else begin
      chk("a_rvalid_idle", 64'(r_valid_a), 64'd0);
      chk("a_idle_out", {31'h0, r_err_a, r_data_a}, 64'd0);
    end
    if (due_b) begin
      h_b = q_b.pop_front();
      chk("b_rvalid", 64'(r_valid_b), 64'd1);
      chk("b_rdata", 64'(r_data_b), 64'(h_b.data));
      chk("b_rerr", 64'(r_err_b), 64'(h_b.err));
    end else begin
      chk("b_rvalid_idle", 64'(r_valid_b), 64'd0);
      chk("b_idle_out", {31'h0, r_err_b, r_data_b}, 64'd0);
    end
    if (rst || err_clr) begin
      cnt_a = 0;
      cnt_b = 0;
    end else begin
      if (due_a && h_a.err && cnt_a < MAX_A) cnt_a++;
      if (due_b && h_b.err && cnt_b < MAX_B) cnt_b++;
    end
  end

  initial begin
    logic [31:0] a;
    for (int i = 0; i < 1024; i++) ref_mem[i] = seed(i);
    @(posedge clk);
    #1;
    init_go = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Read hitting a preloaded word.
    drive(1'b1, 32'h1000_0010, 1'b0, 32'h0, 4'hF, 1'b1, 1'b0);
    idle(4);
    // Memory arbitration holds off the grant for three cycles.
    for (int i = 0; i < 3; i++) drive(1'b1, 32'h1000_0020, 1'b0, 32'h0, 4'hF, 1'b0, 1'b0);
    drive(1'b1, 32'h1000_0020, 1'b0, 32'h0, 4'hF, 1'b1, 1'b0);
    idle(4);
    // Out-of-range read is granted even without a memory grant.
    drive(1'b1, 32'h2000_0000, 1'b0, 32'h0, 4'hF, 1'b0, 1'b0);
    idle(4);
    // Back-to-back write, read, read.
    drive(1'b1, 32'h1000_0040, 1'b1, 32'h1234_5678, 4'hF, 1'b1, 1'b0);
    drive(1'b1, 32'h1000_0040, 1'b0, 32'h0, 4'hF, 1'b1, 1'b0);
    drive(1'b1, 32'h1000_0044, 1'b0, 32'h0, 4'hF, 1'b1, 1'b0);
    idle(5);
    // Partial and empty byte enables.
    drive(1'b1, 32'h1000_0048, 1'b1, 32'hAABB_CCDD, 4'b0101, 1'b1, 1'b0);
    drive(1'b1, 32'h1000_0048, 1'b0, 32'h0, 4'hF, 1'b1, 1'b0);
    drive(1'b1, 32'h1000_004C, 1'b1, 32'hFFFF_FFFF, 4'b0000, 1'b1, 1'b0);
    drive(1'b1, 32'h1000_004C, 1'b0, 32'h0, 4'hF, 1'b1, 1'b0);
    idle(5);
    // Window boundaries.
    drive(1'b1, BASE + 32'hFFC, 1'b0, 32'h0, 4'hF, 1'b1, 1'b0);
    drive(1'b1, BASE + 32'h1000, 1'b0, 32'h0, 4'hF, 1'b1, 1'b0);
    drive(1'b1, BASE - 32'h4, 1'b1, 32'h5, 4'hF, 1'b1, 1'b0);
    idle(5);
    // Enough errors to saturate the 2-bit counter.
    for (int i = 0; i < 4; i++)
      drive(1'b1, 32'h3000_0000 | 32'(i * 4), 1'(i), 32'h0, 4'hF, 1'(i % 2), 1'b0);
    idle(5);
    // A clear coincides with the error response on A, then on B.
    drive(1'b1, 32'h0000_0100, 1'b0, 32'h0, 4'hF, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b1);
    drive(1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b1);
    idle(4);
    // Errors again, then a reset while a read is in flight.
    drive(1'b1, 32'h0, 1'b0, 32'h0, 4'hF, 1'b0, 1'b0);
    idle(4);
    drive(1'b1, 32'h1000_0010, 1'b0, 32'h0, 4'hF, 1'b1, 1'b0);
    do_reset();
    idle(5);

    for (int n = 0; n < 3000; n++) begin
      case ($urandom_range(0, 4))
        0, 1:    a = BASE + 32'($urandom_range(0, 4095));
        2:       a = $urandom;
        3:       a = ($urandom_range(0, 1) == 0) ? BASE + 32'h1000 : BASE - 32'h4;
        default: a = BASE + 32'($urandom_range(0, 15));
      endcase
      drive(1'($urandom_range(0, 3) != 0), a, 1'($urandom_range(0, 1)), $urandom,
            4'($urandom_range(0, 15)), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 31) == 0));
    end
    idle(6);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
